// File: rtl/fft_16.sv
// ============================================================================
// Module   : fft_16
// Brief    : 16-point DFT of 4-bit signed complex samples. Loads 16 samples,
//            computes one complex MAC per cycle for 256 cycles, then streams
//            the 16 bins out in natural order with FFT_Done high.
//            Optional macro FFT_ROUND_EN: outputs are rounded (X+8192)>>>14
//            instead of the raw Q.14 accumulations.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fft_16 (
  input  logic               clk,
  input  logic               reset,
  input  logic signed [3:0]  in_real,
  input  logic signed [3:0]  in_image,
  output logic               FFT_Done,
  output logic signed [37:0] out_real,
  output logic signed [37:0] out_image
);

  typedef enum logic [1:0] {
    ST_LOAD    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_OUTPUT  = 2'd2
  } state_t;

  state_t r_state;
  // LOAD uses [3:0] as sample index, COMPUTE uses {k,n}, OUTPUT uses [4:0]
  logic [7:0]         r_cnt;
  logic signed [3:0]  r_xr [16];
  logic signed [3:0]  r_xi [16];
  logic signed [37:0] r_acc_re;
  logic signed [37:0] r_acc_im;
  logic signed [37:0] r_bin_re [16];
  logic signed [37:0] r_bin_im [16];

  // Q.14 cosine table; sine is the same table delayed by a quarter turn
  function automatic logic signed [15:0] cos_lut(input logic [3:0] m);
    case (m)
      4'd0:    cos_lut = 16'sd16384;
      4'd1:    cos_lut = 16'sd15137;
      4'd2:    cos_lut = 16'sd11585;
      4'd3:    cos_lut = 16'sd6270;
      4'd5:    cos_lut = -16'sd6270;
      4'd6:    cos_lut = -16'sd11585;
      4'd7:    cos_lut = -16'sd15137;
      4'd8:    cos_lut = -16'sd16384;
      4'd9:    cos_lut = -16'sd15137;
      4'd10:   cos_lut = -16'sd11585;
      4'd11:   cos_lut = -16'sd6270;
      4'd13:   cos_lut = 16'sd6270;
      4'd14:   cos_lut = 16'sd11585;
      4'd15:   cos_lut = 16'sd15137;
      default: cos_lut = 16'sd0;
    endcase
  endfunction

  // Output scaling applied when a bin is presented
  function automatic logic signed [37:0] scale_out(input logic signed [37:0] v);
`ifdef FFT_ROUND_EN
    logic signed [37:0] t;
    t = v + 38'sd8192;
    scale_out = t >>> 14;
`else
    scale_out = v;
`endif
  endfunction

  logic [3:0]         w_n;
  logic [3:0]         w_k;
  logic [7:0]         w_nk;
  logic [3:0]         w_m;
  logic signed [15:0] w_c;
  logic signed [15:0] w_s;
  logic signed [19:0] w_a;
  logic signed [19:0] w_b;
  logic signed [19:0] w_c20;
  logic signed [19:0] w_s20;
  logic signed [19:0] w_pr_re;
  logic signed [19:0] w_pr_im;
  logic signed [37:0] w_sum_re;
  logic signed [37:0] w_sum_im;

  // Twiddle index m = (n*k) mod 16 is just the low nibble of the product
  assign w_n     = r_cnt[3:0];
  assign w_k     = r_cnt[7:4];
  assign w_nk    = {4'd0, w_n} * {4'd0, w_k};
  assign w_m     = w_nk[3:0];
  assign w_c     = cos_lut(w_m);
  assign w_s     = cos_lut(w_m - 4'd4);
  assign w_a     = {{16{r_xr[w_n][3]}}, r_xr[w_n]};
  assign w_b     = {{16{r_xi[w_n][3]}}, r_xi[w_n]};
  assign w_c20   = {{4{w_c[15]}}, w_c};
  assign w_s20   = {{4{w_s[15]}}, w_s};
  // (a + jb)(C - jS) = (aC + bS) + j(bC - aS); |result| <= 2^18, fits 20 bits
  assign w_pr_re = (w_a * w_c20) + (w_b * w_s20);
  assign w_pr_im = (w_b * w_c20) - (w_a * w_s20);
  assign w_sum_re = r_acc_re + {{18{w_pr_re[19]}}, w_pr_re};
  assign w_sum_im = r_acc_im + {{18{w_pr_im[19]}}, w_pr_im};

  // Control FSM, sample capture, MAC accumulation and bin output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_LOAD;
      r_cnt     <= '0;
      r_acc_re  <= '0;
      r_acc_im  <= '0;
      FFT_Done  <= 1'b0;
      out_real  <= '0;
      out_image <= '0;
      for (int i = 0; i < 16; i++) begin
        r_xr[i]     <= '0;
        r_xi[i]     <= '0;
        r_bin_re[i] <= '0;
        r_bin_im[i] <= '0;
      end
    end else begin
      case (r_state)
        ST_LOAD: begin
          r_xr[r_cnt[3:0]] <= in_real;
          r_xi[r_cnt[3:0]] <= in_image;
          if (r_cnt[3:0] == 4'd15) begin
            r_state <= ST_COMPUTE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        ST_COMPUTE: begin
          // Last term of bin k: commit the sum and restart the accumulator
          if (w_n == 4'd15) begin
            r_bin_re[w_k] <= w_sum_re;
            r_bin_im[w_k] <= w_sum_im;
            r_acc_re      <= '0;
            r_acc_im      <= '0;
          end else begin
            r_acc_re <= w_sum_re;
            r_acc_im <= w_sum_im;
          end
          if (r_cnt == 8'd255) begin
            r_state <= ST_OUTPUT;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        ST_OUTPUT: begin
          // Count 16 presents one bin per edge; the 17th edge drops Done
          // and returns to LOAD without capturing a sample
          if (r_cnt[4]) begin
            FFT_Done <= 1'b0;
            r_state  <= ST_LOAD;
            r_cnt    <= '0;
          end else begin
            FFT_Done  <= 1'b1;
            out_real  <= scale_out(r_bin_re[r_cnt[3:0]]);
            out_image <= scale_out(r_bin_im[r_cnt[3:0]]);
            r_cnt     <= r_cnt + 8'd1;
          end
        end
        default: begin
          r_state <= ST_LOAD;
          r_cnt   <= '0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fft_16.sv
// ============================================================================
// Module   : tb_fft_16
// Brief    : Directed self-checking bench for fft_16 (impulse, DC, shifted
//            impulse, full-scale negative, scaled complex impulse, and reset
//            aborts in COMPUTE and OUTPUT). Follows FFT_ROUND_EN if defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fft_16;

  logic               clk_tb = 1'b0;
  logic               reset;
  logic signed [3:0]  in_real;
  logic signed [3:0]  in_image;
  logic               FFT_Done;
  logic signed [37:0] out_real;
  logic signed [37:0] out_image;

  int n_cmp = 0;
  int n_err = 0;

  logic signed [3:0]  xr [16];
  logic signed [3:0]  xi [16];
  logic signed [37:0] er [16];
  logic signed [37:0] ei [16];

  localparam int C_TAB [16] = '{16384, 15137, 11585, 6270, 0, -6270, -11585, -15137,
                                -16384, -15137, -11585, -6270, 0, 6270, 11585, 15137};
  localparam int S_TAB [16] = '{0, 6270, 11585, 15137, 16384, 15137, 11585, 6270,
                                0, -6270, -11585, -15137, -16384, -15137, -11585, -6270};

  always #5 clk_tb = ~clk_tb;

  fft_16 dut (
    .clk       (clk_tb),
    .reset     (reset),
    .in_real   (in_real),
    .in_image  (in_image),
    .FFT_Done  (FFT_Done),
    .out_real  (out_real),
    .out_image (out_image)
  );

  task automatic chk(input string tag, input logic signed [37:0] got,
                     input logic signed [37:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Expected output for a raw Q.14 value in the current build
  function automatic logic signed [37:0] sc(input longint v);
`ifdef FFT_ROUND_EN
    return 38'((v + 64'sd8192) >>> 14);
`else
    return 38'(v);
`endif
  endfunction

  // Directed vectors with hand-derived bin values
  task automatic load_vec(input int id);
    for (int i = 0; i < 16; i++) begin
      xr[i] = 4'sd0;
      xi[i] = 4'sd0;
    end
    for (int k = 0; k < 16; k++) begin
      er[k] = sc(0);
      ei[k] = sc(0);
    end
    case (id)
      0: begin  // impulse 1+j0 at n=0
        xr[0] = 4'sd1;
        for (int k = 0; k < 16; k++) er[k] = sc(16384);
      end
      1: begin  // DC 1+j0
        for (int i = 0; i < 16; i++) xr[i] = 4'sd1;
        er[0] = sc(262144);
      end
      2: begin  // impulse at n=1: X[k] = C[k] - jS[k]
        xr[1] = 4'sd1;
        for (int k = 0; k < 16; k++) begin
          er[k] = sc(C_TAB[k]);
          ei[k] = sc(-S_TAB[k]);
        end
      end
      3: begin  // all -8-j8
        for (int i = 0; i < 16; i++) begin
          xr[i] = -4'sd8;
          xi[i] = -4'sd8;
        end
        er[0] = sc(-2097152);
        ei[0] = sc(-2097152);
      end
      default: begin  // impulse 2-j3 at n=0
        xr[0] = 4'sd2;
        xi[0] = -4'sd3;
        for (int k = 0; k < 16; k++) begin
          er[k] = sc(32768);
          ei[k] = sc(-49152);
        end
      end
    endcase
  endtask

  // Entered at a negedge; edge e=1 is the first capture edge of the frame
  task automatic run_frame(input string name, input int n_edges);
    for (int e = 1; e <= n_edges; e++) begin
      if (e <= 16) begin
        in_real  = xr[e-1];
        in_image = xi[e-1];
      end else begin
        in_real  = 4'($urandom);
        in_image = 4'($urandom);
      end
      @(posedge clk_tb);
      #1;
      if (e >= 273 && e <= 288) begin
        chk($sformatf("%s done e%0d", name, e), 38'(FFT_Done), 38'sd1);
        chk($sformatf("%s re X%0d", name, e - 273), out_real, er[e-273]);
        chk($sformatf("%s im X%0d", name, e - 273), out_image, ei[e-273]);
      end else begin
        chk($sformatf("%s done e%0d", name, e), 38'(FFT_Done), 38'sd0);
      end
      if (e == 289) begin
        chk($sformatf("%s hold re", name), out_real, er[15]);
        chk($sformatf("%s hold im", name), out_image, ei[15]);
      end
      @(negedge clk_tb);
    end
  endtask

  // Asynchronous reset pulse; leaves at a negedge with reset released
  task automatic do_reset(input string name);
    @(negedge clk_tb);
    reset = 1'b0;
    #1;
    chk($sformatf("%s rst done", name), 38'(FFT_Done), 38'sd0);
    chk($sformatf("%s rst re", name), out_real, 38'sd0);
    chk($sformatf("%s rst im", name), out_image, 38'sd0);
    repeat (3) @(negedge clk_tb);
    reset = 1'b1;
  endtask

  initial begin
    reset    = 1'b0;
    in_real  = 4'sd0;
    in_image = 4'sd0;
    repeat (2) @(posedge clk_tb);
    do_reset("init");

    load_vec(0); run_frame("impulse", 289);
    load_vec(2); run_frame("shift", 289);      // back-to-back frame
    load_vec(1); run_frame("dc_abort", 116);   // abort at COMPUTE cycle 100
    do_reset("abort_cmp");
    load_vec(1); run_frame("dc", 289);
    load_vec(3); run_frame("neg8", 289);
    load_vec(4); run_frame("cplx_abort", 280); // abort mid-OUTPUT
    do_reset("abort_out");
    load_vec(4); run_frame("cplx", 289);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fft_16.md
FFT_16 -- requirements
Module: fft_16

Interface
REQ-001 The block SHALL have no parameters; the transform size is fixed at 16 points.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset: low clears all state immediately; high releases it.
REQ-004 in_real  input  4  real part of the current time-domain sample, signed two's complement (-8..7).
REQ-005 in_image  input  4  imaginary part of the current sample, signed two's complement.
REQ-006 FFT_Done  output  1  high while out_real/out_image carry a valid frequency bin.
REQ-007 out_real  output  38  real part of the current bin, signed two's complement.
REQ-008 out_image  output  38  imaginary part of the current bin, signed two's complement.

Function
REQ-009 The block SHALL run a three-state FSM: LOAD -> COMPUTE -> OUTPUT -> LOAD.
REQ-010 LOAD: on each of 16 consecutive rising edges, the block SHALL capture {in_real, in_image} as x[0]..x[15] in order.
- The state SHALL enter COMPUTE on the edge that captures x[15].
REQ-011 Inputs SHALL be ignored in COMPUTE and OUTPUT.
REQ-012 COMPUTE SHALL last exactly 256 cycles and SHALL then enter OUTPUT; any datapath architecture is allowed if results are bit-exact.
REQ-013 Bin definition: X[k] = sum over n=0..15 of x[n]*W(m), with m = (n*k) mod 16.
REQ-014 Twiddle: W(m) = C[m] - j*S[m], where C[m] = round(16384*cos(2*pi*m/16)) and S[m] = round(16384*sin(2*pi*m/16)).
- First-quadrant magnitudes: 16384, 15137, 11585, 6270, 0.
- Other quadrants by symmetry, with the signs of cos/sin.
REQ-015 Complex product: (a + jb)(C - jS) = (aC + bS) + j(bC - aS); accumulation SHALL be exact integer arithmetic with no truncation, sign-extended to 38 bits.
REQ-016 OUTPUT SHALL last 16 cycles: FFT_Done=1 with X[0]..X[15] presented one bin per cycle in natural order.
- On the next edge FFT_Done SHALL fall to 0 and the state SHALL return to LOAD.
- That edge SHALL NOT capture a sample; the following 16 edges capture the next frame.
REQ-017 Timing from reset release: FFT_Done SHALL rise on rising edge 273 and stay high through edge 288.
REQ-018 Outside OUTPUT, FFT_Done SHALL be 0 and out_real/out_image SHALL hold their last driven value.

Reset
REQ-019 While reset is low, the block SHALL force:
- state = LOAD, all counters = 0, sample and result storage = 0;
- FFT_Done = 0, out_real = 0, out_image = 0.
REQ-020 Reset asserted mid-LOAD, mid-COMPUTE or mid-OUTPUT SHALL abort the frame; the first edge after release SHALL capture x[0].

Configuration
REQ-021 Macro FFT_ROUND_EN:
- Defined: each output SHALL be (X + 8192) >>> 14, i.e. an arithmetic shift of 14 with round-half-up, sign-extended to 38 bits.
- Undefined: outputs SHALL be the raw Q.14 accumulations of REQ-015.
- Timing SHALL be identical in both builds.

Verification (FFT_ROUND_EN undefined unless stated)
REQ-022 Impulse x[0]=1+j0, all others 0 -> every bin out_real=16384, out_image=0.
REQ-023 DC x[n]=1+j0 for all n -> X[0]=262144+j0; X[1..15]=0+j0; FFT_Done high exactly on edges 273..288.
REQ-024 Shifted impulse x[1]=1, others 0 -> X[4]=0-j16384, X[2]=11585-j11585, X[8]=-16384+j0.
REQ-025 All samples -8-j8 -> X[0]=-2097152-j2097152; other bins 0; no overflow.
REQ-026 Reset pulsed low at COMPUTE cycle 100 -> FFT_Done stays 0, outputs 0; a new frame completes 288 edges after release.
REQ-027 FFT_ROUND_EN defined, DC input all 1 -> X[0]=16+j0; the shifted impulse gives X[2]=1-j1.
